// File: rtl/pipe_test_pkg.sv
// Shared types and helpers for the PipeTest arbitration blocks.
package pipe_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Slack kept between FIFO fill and a full burst: output register plus count latency.
  localparam int unsigned HEADROOM_MARGIN = 2;

  // Index width for n items; never below 1 so single-source builds keep real vectors.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_out_arbiter_if.sv
// Generator/FIFO side bundle of the Pipe Out arbiter.
// Statistics ports exist only when PIPE_ARB_STATS_EN is defined.
interface pipe_out_arbiter_if
  import pipe_test_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned COUNT_W = 9
);
  localparam int unsigned SEL_W = clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_req;
  logic [NUM_SRC-1:0]        src_write;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_grant;
  logic [COUNT_W-1:0]        fifo_count;
  logic                      fifo_write;
  logic [DATA_W-1:0]         fifo_data;
  logic                      burst_done;
  logic                      proto_err;
`ifdef PIPE_ARB_STATS_EN
  logic [SEL_W-1:0]          stat_sel;
  logic [31:0]               stat_words;

  modport master (
    input  src_req, src_write, src_data, fifo_count, stat_sel,
    output src_grant, fifo_write, fifo_data, burst_done, proto_err, stat_words
  );
  modport slave (
    output src_req, src_write, src_data, fifo_count, stat_sel,
    input  src_grant, fifo_write, fifo_data, burst_done, proto_err, stat_words
  );
`else
  modport master (
    input  src_req, src_write, src_data, fifo_count,
    output src_grant, fifo_write, fifo_data, burst_done, proto_err
  );
  modport slave (
    output src_req, src_write, src_data, fifo_count,
    input  src_grant, fifo_write, fifo_data, burst_done, proto_err
  );
`endif
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module rr_pick
  import pipe_test_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             valid_c
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] j;

  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    valid_c  = 1'b0;
    sum      = '0;
    j        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      j = sum[IDX_W-1:0];
      if (!valid_c && req[j]) begin
        valid_c     = 1'b1;
        onehot_c[j] = 1'b1;
        idx_c       = j;
      end
    end
  end

endmodule

// File: rtl/pipe_out_arbiter.sv
// Round-robin burst arbiter sharing one Pipe Out FIFO write port among NUM_SRC generators.
// Optional per-source word counters are enabled with PIPE_ARB_STATS_EN.
module pipe_out_arbiter
  import pipe_test_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned COUNT_W    = 9,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic               clk,
  input  logic               reset,
  pipe_out_arbiter_if.master bus
);

  localparam int unsigned IDX_W  = clog2(NUM_SRC);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned THRESH = FIFO_DEPTH - BURST_LEN - HEADROOM_MARGIN;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               fifo_write_q;
  logic [DATA_W-1:0]  fifo_data_q;
  logic               proto_err_q;

  logic [NUM_SRC-1:0] pick_onehot_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_valid_c;
  logic               headroom_c;
  logic               accept_c;
  logic               illegal_c;
  logic [IDX_W-1:0]   next_ptr_c;
  logic [DATA_W-1:0]  sel_data_c;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req      (bus.src_req),
    .ptr      (ptr_q),
    .onehot_c (pick_onehot_c),
    .idx_c    (pick_idx_c),
    .valid_c  (pick_valid_c)
  );

  // Headroom, word acceptance and ownership violations
  always_comb begin
    headroom_c = 32'(bus.fifo_count) <= THRESH;
    accept_c   = (state_q == GRANT) && bus.src_write[gidx_q];
    illegal_c  = |(bus.src_write & ((state_q == GRANT) ? ~grant_q : {NUM_SRC{1'b1}}));
    next_ptr_c = (gidx_q == IDX_W'(NUM_SRC - 1)) ? '0 : gidx_q + IDX_W'(1);
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gidx_q == IDX_W'(i)) sel_data_c = bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and grant bookkeeping
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid_c && headroom_c) begin
          state_d = GRANT;
          grant_d = pick_onehot_c;
          gidx_d  = pick_idx_c;
        end
      end
      GRANT: begin
        if (accept_c) cnt_d = cnt_q + CNT_W'(1);
        if ((accept_c && cnt_q == CNT_W'(BURST_LEN - 1)) || !bus.src_req[gidx_q]) begin
          state_d = GAP;
          grant_d = '0;
          done_d  = 1'b1;
          ptr_d   = next_ptr_c;
          cnt_d   = '0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Registered write mux; data holds between accepted words
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      fifo_write_q <= accept_c;
      if (accept_c) fifo_data_q <= sel_data_c;
      proto_err_q  <= proto_err_q | illegal_c;
    end
  end

  assign bus.src_grant  = grant_q;
  assign bus.fifo_write = fifo_write_q;
  assign bus.fifo_data  = fifo_data_q;
  assign bus.burst_done = done_q;
  assign bus.proto_err  = proto_err_q;

`ifdef PIPE_ARB_STATS_EN
  logic [31:0] stat_cnt_q [NUM_SRC];
  logic [31:0] stat_words_q;
  logic [31:0] stat_sel_c;

  always_comb begin
    stat_sel_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.stat_sel == IDX_W'(i)) stat_sel_c = stat_cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) stat_cnt_q[i] <= '0;
      stat_words_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (accept_c && gidx_q == IDX_W'(i)) stat_cnt_q[i] <= stat_cnt_q[i] + 32'd1;
      end
      stat_words_q <= stat_sel_c;
    end
  end

  assign bus.stat_words = stat_words_q;
`endif

endmodule
